// File: rtl/sdram_chip_model_if.sv
// sdram_chip_model_if: controller-to-SDRAM pin bundle for the chip model.
// master = SDRAM controller side, slave = chip model side.
interface sdram_chip_model_if;
  localparam int unsigned DQ_W   = 32;
  localparam int unsigned DQM_W  = 4;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned BA_W   = 2;

  logic              cke_i;
  logic              cs_i;
  logic              ras_i;
  logic              cas_i;
  logic              we_i;
  logic [DQM_W-1:0]  dqm_i;
  logic [ADDR_W-1:0] addr_i;
  logic [BA_W-1:0]   ba_i;
  logic [DQ_W-1:0]   dq_i;
  logic              dq_oe_i;
  logic [DQ_W-1:0]   dq_o;
  logic              err_o;

  modport master (
    output cke_i, cs_i, ras_i, cas_i, we_i, dqm_i, addr_i, ba_i, dq_i, dq_oe_i,
    input  dq_o, err_o
  );

  modport slave (
    input  cke_i, cs_i, ras_i, cas_i, we_i, dqm_i, addr_i, ba_i, dq_i, dq_oe_i,
    output dq_o, err_o
  );
endinterface

// File: rtl/sdram_chip_model.sv
// sdram_chip_model: single-chip 32-bit SDR SDRAM responder.
// Decodes SDRAM commands, tracks open rows per bank and the mode register,
// runs one read/write burst engine over an internal word array and returns
// read data through a CAS-latency pipeline.
// Optional macro SDRAM_MODEL_PROTO_CHECK_EN enables the sticky protocol-error
// flag on err_o; without it err_o is tied low.
module sdram_chip_model #(
  parameter int unsigned MEM_ADDR_W = 16,
  parameter int unsigned ROW_W      = 13,
  parameter int unsigned COL_W      = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  sdram_chip_model_if.slave bus
);
  localparam int unsigned NBANK  = 4;
  localparam int unsigned BA_W   = 2;
  localparam int unsigned DQ_W   = 32;
  localparam int unsigned NBYTE  = 4;
  localparam int unsigned BEAT_W = 3;
  localparam int unsigned LIN_W  = BA_W + ROW_W + COL_W;
  localparam int unsigned DEPTH  = 1 << MEM_ADDR_W;

  localparam logic [2:0] CMD_LMR = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_BST = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RBURST = 2'd1,
    ST_WBURST = 2'd2
  } state_t;

  // Bank / mode state
  logic [NBANK-1:0] r_open;
  logic [ROW_W-1:0] r_row [NBANK];
  logic [1:0]       r_bl;     // burst length code: 1,2,4,8 beats
  logic             r_cl3;    // 0 = CL2, 1 = CL3

  // Burst engine state
  state_t            r_state;
  state_t            w_state_nx;
  logic [BA_W-1:0]   r_bank;
  logic [ROW_W-1:0]  r_brow;
  logic [COL_W-1:0]  r_col;
  logic [BEAT_W-1:0] r_beat;
  logic [1:0]        r_bbl;
  logic              r_bcl3;
  logic              r_ap;

  // Storage and read pipeline
  logic [DQ_W-1:0]   r_mem [0:DEPTH-1];
  logic [DQ_W-1:0]   r_rdata;
  logic              r_p0_vld;
  logic              r_p0_cl3;
  logic [NBYTE-1:0]  r_p0_dqm;
  logic              r_p1_vld;
  logic [DQ_W-1:0]   r_p1_data;
  logic [DQ_W-1:0]   r_dq;

  // Decode / datapath wires
  logic              w_cmd_en;
  logic [2:0]        w_cmd;
  logic              w_is_rw;
  logic              w_bst;
  logic [2:0]        w_lmr_bl;
  logic [2:0]        w_lmr_cl;
  logic              w_mode_ok;
  logic [BEAT_W-1:0] w_last;
  logic [BEAT_W-1:0] w_beat_nx;
  logic              w_ld_burst;
  logic              w_rd_en;
  logic              w_wr_en;
  logic              w_ap_close;
  logic [BA_W-1:0]   w_bank;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col;
  logic [BEAT_W-1:0] w_beat_idx;
  logic [1:0]        w_blc;
  logic              w_cl3;
  logic [COL_W-1:0]  w_lowmask;
  logic [COL_W-1:0]  w_col_beat;
  logic [LIN_W-1:0]  w_lin;
  logic [MEM_ADDR_W-1:0] w_addr;
  logic [DQ_W-1:0]   w_p0_data;
  logic              w_unused;

  assign w_cmd_en  = bus.cke_i & ~bus.cs_i;
  assign w_cmd     = {bus.ras_i, bus.cas_i, bus.we_i};
  assign w_is_rw   = w_cmd_en & ((w_cmd == CMD_RD) | (w_cmd == CMD_WR));
  assign w_bst     = w_cmd_en & (w_cmd == CMD_BST);
  assign w_lmr_bl  = bus.addr_i[2:0];
  assign w_lmr_cl  = bus.addr_i[6:4];
  assign w_mode_ok = (w_lmr_bl <= 3'd3) & ((w_lmr_cl == 3'd2) | (w_lmr_cl == 3'd3));

  // Index of the final beat of the active burst
  always_comb begin
    w_last = BEAT_W'(0);
    case (r_bbl)
      2'd0:    w_last = BEAT_W'(0);
      2'd1:    w_last = BEAT_W'(1);
      2'd2:    w_last = BEAT_W'(3);
      default: w_last = BEAT_W'(7);
    endcase
  end

  // Burst FSM next state plus per-cycle beat selection; a new READ/WRITE
  // always wins over the running burst, and the BST cycle still issues its beat
  always_comb begin
    w_state_nx = r_state;
    w_beat_nx  = r_beat;
    w_ld_burst = 1'b0;
    w_rd_en    = 1'b0;
    w_wr_en    = 1'b0;
    w_ap_close = 1'b0;
    w_bank     = r_bank;
    w_row      = r_brow;
    w_col      = r_col;
    w_beat_idx = r_beat;
    w_blc      = r_bbl;
    w_cl3      = r_bcl3;
    if (w_is_rw) begin
      w_ld_burst = 1'b1;
      w_bank     = bus.ba_i;
      w_row      = r_row[bus.ba_i];
      w_col      = bus.addr_i[COL_W-1:0];
      w_beat_idx = BEAT_W'(0);
      w_blc      = r_bl;
      w_cl3      = r_cl3;
      w_rd_en    = (w_cmd == CMD_RD);
      w_wr_en    = (w_cmd == CMD_WR);
      if (r_bl == 2'd0) begin
        w_state_nx = ST_IDLE;
        w_ap_close = bus.addr_i[10];
      end else begin
        w_state_nx = (w_cmd == CMD_RD) ? ST_RBURST : ST_WBURST;
        w_beat_nx  = BEAT_W'(1);
      end
    end else if (bus.cke_i && (r_state != ST_IDLE)) begin
      w_rd_en = (r_state == ST_RBURST);
      w_wr_en = (r_state == ST_WBURST);
      if ((r_beat == w_last) || w_bst) begin
        w_state_nx = ST_IDLE;
        w_ap_close = r_ap;
      end else begin
        w_beat_nx = r_beat + BEAT_W'(1);
      end
    end
  end

  // Sequential wrap of the column inside the BL-aligned block
  assign w_lowmask  = COL_W'((32'd1 << w_blc) - 32'd1);
  assign w_col_beat = (w_col & ~w_lowmask) | ((w_col + COL_W'(w_beat_idx)) & w_lowmask);
  assign w_lin      = {w_bank, w_row, w_col_beat};
  assign w_addr     = w_lin[MEM_ADDR_W-1:0];

  // Burst FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  // Burst context latched on READ/WRITE; beat counter advances per enabled cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bank <= '0;
      r_brow <= '0;
      r_col  <= '0;
      r_beat <= '0;
      r_bbl  <= '0;
      r_bcl3 <= 1'b0;
      r_ap   <= 1'b0;
    end else begin
      r_beat <= w_beat_nx;
      if (w_ld_burst) begin
        r_bank <= bus.ba_i;
        r_brow <= r_row[bus.ba_i];
        r_col  <= bus.addr_i[COL_W-1:0];
        r_bbl  <= r_bl;
        r_bcl3 <= r_cl3;
        r_ap   <= bus.addr_i[10];
      end
    end
  end

  // Open-row tracking and mode register; ACTIVE wins over a same-cycle auto-precharge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_open <= '0;
      r_bl   <= 2'd0;
      r_cl3  <= 1'b0;
      for (int unsigned i = 0; i < NBANK; i++) r_row[i] <= '0;
    end else begin
      if (w_ap_close) r_open[w_bank] <= 1'b0;
      if (w_cmd_en) begin
        case (w_cmd)
          CMD_ACT: begin
            r_open[bus.ba_i] <= 1'b1;
            r_row[bus.ba_i]  <= bus.addr_i[ROW_W-1:0];
          end
          CMD_PRE: begin
            if (bus.addr_i[10]) r_open <= '0;
            else                r_open[bus.ba_i] <= 1'b0;
          end
          CMD_LMR: begin
            // unsupported settings leave the mode register untouched
            if (w_mode_ok) begin
              r_bl  <= w_lmr_bl[1:0];
              r_cl3 <= (w_lmr_cl == 3'd3);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Byte-masked array write; array contents are deliberately not reset
  always_ff @(posedge clk_i) begin
    if (w_wr_en && bus.dq_oe_i) begin
      for (int unsigned b = 0; b < NBYTE; b++) begin
        if (!bus.dqm_i[b]) r_mem[w_addr][8*b +: 8] <= bus.dq_i[8*b +: 8];
      end
    end
  end

  // Synchronous array read forms the first CAS-latency stage
  always_ff @(posedge clk_i) begin
    if (w_rd_en) r_rdata <= r_mem[w_addr];
  end

  // DQM captured with the read beat zeroes the masked bytes
  always_comb begin
    w_p0_data = r_rdata;
    for (int unsigned b = 0; b < NBYTE; b++) begin
      if (r_p0_dqm[b]) w_p0_data[8*b +: 8] = 8'h00;
    end
  end

  // Read latency pipeline: CL2 leaves from stage 0, CL3 via stage 1; frozen while cke is low
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_p0_vld  <= 1'b0;
      r_p0_cl3  <= 1'b0;
      r_p0_dqm  <= '0;
      r_p1_vld  <= 1'b0;
      r_p1_data <= '0;
      r_dq      <= '0;
    end else if (bus.cke_i) begin
      r_p0_vld  <= w_rd_en;
      r_p0_cl3  <= w_cl3;
      r_p0_dqm  <= bus.dqm_i;
      r_p1_vld  <= r_p0_vld & r_p0_cl3;
      r_p1_data <= w_p0_data;
      if (r_p1_vld)                    r_dq <= r_p1_data;
      else if (r_p0_vld && !r_p0_cl3)  r_dq <= w_p0_data;
    end
  end

  assign bus.dq_o = r_dq;

`ifdef SDRAM_MODEL_PROTO_CHECK_EN
  logic w_prot_err;
  logic r_err;

  // Protocol violations observed this cycle
  always_comb begin
    w_prot_err = 1'b0;
    if (w_cmd_en) begin
      case (w_cmd)
        CMD_ACT:         w_prot_err = r_open[bus.ba_i];
        CMD_RD, CMD_WR:  w_prot_err = ~r_open[bus.ba_i];
        CMD_REF:         w_prot_err = |r_open;
        CMD_LMR:         w_prot_err = (|r_open) | ~w_mode_ok;
        default:         w_prot_err = 1'b0;
      endcase
    end
    if (w_wr_en && !bus.dq_oe_i) w_prot_err = 1'b1;
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           r_err <= 1'b0;
    else if (w_prot_err) r_err <= 1'b1;
  end

  assign bus.err_o = r_err;
`else
  assign bus.err_o = 1'b0;
`endif

  // Address bits beyond the row field and truncated linear-address bits
  assign w_unused = ^{bus.addr_i, w_lin};

endmodule

// File: tb/tb_sdram_chip_model.sv
// tb_sdram_chip_model: directed table-driven bench for sdram_chip_model,
// with hand-written sequences for clock suspend, error flag and reset.
module tb_sdram_chip_model;
  localparam logic [2:0] C_LMR = 3'b000;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_BST = 3'b110;
  localparam logic [2:0] C_NOP = 3'b111;

`ifdef SDRAM_MODEL_PROTO_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic        cke;
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [13:0] addr;
    logic [3:0]  dqm;
    logic [31:0] dq;
    logic        oe;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];

  sdram_chip_model_if bus();

  sdram_chip_model #(
    .MEM_ADDR_W(16),
    .ROW_W     (13),
    .COL_W     (10)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] cmd, input logic [1:0] ba,
                              input logic [13:0] addr, input logic [3:0] dqm,
                              input logic [31:0] dq, input logic oe,
                              input logic chk, input logic [31:0] exp);
    vec_t v;
    v.cke = 1'b1; v.cmd = cmd; v.ba = ba; v.addr = addr; v.dqm = dqm;
    v.dq = dq; v.oe = oe; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  function automatic vec_t cv(input logic [2:0] cmd, input logic [1:0] ba, input logic [13:0] addr);
    return mk(cmd, ba, addr, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endfunction

  function automatic vec_t wv(input logic [2:0] cmd, input logic [1:0] ba, input logic [13:0] addr,
                              input logic [3:0] dqm, input logic [31:0] dq);
    return mk(cmd, ba, addr, dqm, dq, 1'b1, 1'b0, 32'h0);
  endfunction

  function automatic vec_t ev(input logic [31:0] exp);
    return mk(C_NOP, 2'd0, 14'd0, 4'h0, 32'h0, 1'b0, 1'b1, exp);
  endfunction

  function automatic vec_t nv();
    return cv(C_NOP, 2'd0, 14'd0);
  endfunction

  // drive one cycle's inputs, let the edge happen, settle 1 time unit after it
  task automatic apply(input vec_t v);
    bus.cke_i   = v.cke;
    bus.cs_i    = 1'b0;
    {bus.ras_i, bus.cas_i, bus.we_i} = v.cmd;
    bus.ba_i    = v.ba;
    bus.addr_i  = v.addr;
    bus.dqm_i   = v.dqm;
    bus.dq_i    = v.dq;
    bus.dq_oe_i = v.oe;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  initial begin
    // A: CL2 BL2 write/read on bank 1 row 5
    tbl.push_back(cv(C_LMR, 2'd0, 14'h021));
    tbl.push_back(cv(C_ACT, 2'd1, 14'd5));
    tbl.push_back(wv(C_WR,  2'd1, 14'd0, 4'h0, 32'h11223344));
    tbl.push_back(wv(C_NOP, 2'd0, 14'd0, 4'h0, 32'h55667788));
    tbl.push_back(cv(C_RD,  2'd1, 14'd0));
    tbl.push_back(nv());
    tbl.push_back(ev(32'h11223344));
    tbl.push_back(ev(32'h55667788));
    tbl.push_back(ev(32'h55667788));
    // B: preload cols 2,3 then CL3 BL4 wrapped read from col 2
    tbl.push_back(wv(C_WR,  2'd1, 14'd2, 4'h0, 32'hA0000002));
    tbl.push_back(wv(C_NOP, 2'd0, 14'd0, 4'h0, 32'hA0000003));
    tbl.push_back(cv(C_PRE, 2'd1, 14'd0));
    tbl.push_back(cv(C_LMR, 2'd0, 14'h032));
    tbl.push_back(cv(C_ACT, 2'd1, 14'd5));
    tbl.push_back(cv(C_RD,  2'd1, 14'd2));
    tbl.push_back(nv());
    tbl.push_back(nv());
    tbl.push_back(ev(32'hA0000002));
    tbl.push_back(ev(32'hA0000003));
    tbl.push_back(ev(32'h11223344));
    tbl.push_back(ev(32'h55667788));
    tbl.push_back(ev(32'h55667788));
    // C: byte-masked write over zeros, then masked read
    tbl.push_back(wv(C_WR,  2'd1, 14'd8, 4'h0, 32'h0));
    for (int i = 0; i < 3; i++) tbl.push_back(wv(C_NOP, 2'd0, 14'd0, 4'h0, 32'h0));
    tbl.push_back(wv(C_WR,  2'd1, 14'd8, 4'b0101, 32'hAABBCCDD));
    for (int i = 0; i < 3; i++) tbl.push_back(wv(C_NOP, 2'd0, 14'd0, 4'hF, 32'hFFFFFFFF));
    tbl.push_back(cv(C_RD,  2'd1, 14'd8));
    tbl.push_back(nv());
    tbl.push_back(nv());
    tbl.push_back(ev(32'hAA00CC00));
    for (int i = 0; i < 3; i++) tbl.push_back(ev(32'h0));
    tbl.push_back(mk(C_RD, 2'd1, 14'd8, 4'b1000, 32'h0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(nv());
    tbl.push_back(nv());
    tbl.push_back(ev(32'h0000CC00));
    for (int i = 0; i < 3; i++) tbl.push_back(ev(32'h0));
    // D: CL2 BL8 read terminated at T+2, then read cut short by a write
    tbl.push_back(cv(C_PRE, 2'd1, 14'd0));
    tbl.push_back(cv(C_LMR, 2'd0, 14'h023));
    tbl.push_back(cv(C_ACT, 2'd1, 14'd5));
    tbl.push_back(cv(C_RD,  2'd1, 14'd0));
    tbl.push_back(nv());
    tbl.push_back(mk(C_BST, 2'd0, 14'd0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h11223344));
    tbl.push_back(ev(32'h55667788));
    tbl.push_back(ev(32'hA0000002));
    tbl.push_back(ev(32'hA0000002));
    tbl.push_back(ev(32'hA0000002));
    tbl.push_back(cv(C_RD,  2'd1, 14'd0));
    tbl.push_back(wv(C_WR,  2'd1, 14'd16, 4'h0, 32'h12345678));
    tbl.push_back(mk(C_BST, 2'd0, 14'd0, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h11223344));
    tbl.push_back(ev(32'h11223344));
    tbl.push_back(cv(C_RD,  2'd1, 14'd16));
    tbl.push_back(cv(C_BST, 2'd0, 14'd0));
    tbl.push_back(ev(32'h12345678));
    tbl.push_back(nv());
    tbl.push_back(nv());

    // reset
    rst = 1'b1;
    bus.cke_i = 1'b1; bus.cs_i = 1'b1; bus.ras_i = 1'b1; bus.cas_i = 1'b1; bus.we_i = 1'b1;
    bus.dqm_i = 4'h0; bus.addr_i = 14'd0; bus.ba_i = 2'd0; bus.dq_i = 32'h0; bus.dq_oe_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_dq", bus.dq_o, 32'h0);
    check("reset_err", {31'd0, bus.err_o}, 32'h0);

    // table vectors: each check is the value the controller samples at that record's edge
    foreach (tbl[i]) begin
      if (tbl[i].chk) check($sformatf("vec%0d", i), bus.dq_o, tbl[i].exp);
      apply(tbl[i]);
    end

    // clock suspend for 3 cycles in the middle of a CL2 BL4 read
    begin
      vec_t v;
      apply(cv(C_PRE, 2'd1, 14'd0));
      apply(cv(C_LMR, 2'd0, 14'h022));
      apply(cv(C_ACT, 2'd1, 14'd5));
      apply(cv(C_RD,  2'd1, 14'd0));
      apply(nv());
      check("cke_b0", bus.dq_o, 32'h11223344);
      v = nv();
      v.cke = 1'b0;
      for (int i = 0; i < 3; i++) begin
        apply(v);
        check($sformatf("cke_hold%0d", i), bus.dq_o, 32'h11223344);
      end
      apply(nv());
      check("cke_b1", bus.dq_o, 32'h55667788);
      apply(nv());
      check("cke_b2", bus.dq_o, 32'hA0000002);
      apply(nv());
      check("cke_b3", bus.dq_o, 32'hA0000003);
      apply(nv());
      check("cke_end", bus.dq_o, 32'hA0000003);
    end

    // protocol error: READ to idle bank 2
    check("err_clean", {31'd0, bus.err_o}, 32'h0);
    apply(cv(C_RD, 2'd2, 14'd0));
    check("err_set", {31'd0, bus.err_o}, {31'd0, ERR_EXP});
    repeat (3) apply(nv());
    check("err_sticky", {31'd0, bus.err_o}, {31'd0, ERR_EXP});

    // asynchronous reset pulse mid-run
    rst = 1'b1;
    #2;
    check("rst2_err", {31'd0, bus.err_o}, 32'h0);
    check("rst2_dq", bus.dq_o, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // mode back to CL2 BL1, array contents kept
    apply(cv(C_ACT, 2'd1, 14'd5));
    apply(cv(C_RD,  2'd1, 14'd1));
    apply(nv());
    check("bl1_beat", bus.dq_o, 32'h55667788);
    apply(nv());
    check("bl1_hold", bus.dq_o, 32'h55667788);
    check("final_err", {31'd0, bus.err_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_chip_model.md
Name: sdram_chip_model

Overview:
- Synthesizable single-chip 32-bit SDR SDRAM responder for the SoC simulation and FPGA flows.
- Connects directly to the SDRAM controller's pins: command, address, DQM, DQ-out/enable in; DQ-in out.
- Decodes JEDEC-style commands and tracks per-bank open rows, the mode register, and read/write bursts.
- Backs storage with an internal word array; returns read data after the programmed CAS latency.

Parameters:
- MEM_ADDR_W, 16, log2 of word-array depth; the linear word address {ba,row,col} is truncated to this width.
- ROW_W, 13, row address bits taken from addr_i.
- COL_W, 10, column bits taken from addr_i[COL_W-1:0] on READ/WRITE.

Ports:
- clk_i  in  1  clock; all commands sampled on the rising edge.
- rst_i  in  1  asynchronous active-high reset.
- cke_i  in  1  clock enable; low means suspend.
- cs_i  in  1  chip select, active low.
- ras_i  in  1  row strobe, active low.
- cas_i  in  1  column strobe, active low.
- we_i  in  1  write enable, active low.
- dqm_i  in  4  byte masks; 1 = masked.
- addr_i  in  14  row/column/mode address; addr_i[10] = all-banks / auto-precharge.
- ba_i  in  2  bank address.
- dq_i  in  32  write data driven by the controller.
- dq_oe_i  in  1  controller DQ output enable.
- dq_o  out  32  read data, registered.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async):
  - dq_o=0, err_o=0.
  - All banks idle; mode register = CL2, BL1.
  - Burst and read pipeline cleared. Array contents are not reset.
- Command decode {ras,cas,we}, with cs_i=0 and cke_i=1:
  - 011 ACTIVE: open row addr_i[ROW_W-1:0] in bank ba_i.
  - 101 READ.
  - 100 WRITE.
  - 010 PRECHARGE: close bank ba_i, or all banks if addr_i[10]=1.
  - 001 AUTO REFRESH: no state change.
  - 000 LOAD MODE: BL=addr_i[2:0] (0,1,2,3 -> 1,2,4,8 beats); CL=addr_i[6:4] (2 or 3).
  - 110 BURST TERMINATE: stop the current burst; read data already in the pipeline still emerges.
  - 111 NOP. cs_i=1 is also a NOP.
- cke_i=0: the cycle is ignored entirely. No decode, burst counter holds, read pipeline holds, dq_o holds.
- Burst state machine: IDLE, RBURST, WBURST.
  - READ or WRITE latches bank, row (from that bank's open-row register), start column, and beat=0. Next state is RBURST or WBURST.
  - Each subsequent cycle advances beat; returns to IDLE after BL beats.
  - Column of beat k = {col[COL_W-1:log2 BL], (col[log2 BL-1:0]+k) mod BL}, i.e. sequential wrap inside the BL-aligned block.
  - A new READ/WRITE during any burst restarts immediately; the old burst is truncated.
  - addr_i[10]=1 on READ/WRITE closes the bank when the burst completes.
- Write beat (including the WRITE command cycle itself):
  - Byte b is written from dq_i[8b+7:8b] iff dqm_i[b]=0 and dq_oe_i=1.
- Read beat k:
  - Issued in cycle T+k, where T is the READ command edge.
  - Array word is read, and the DQM sampled in the same cycle zeroes masked bytes.
  - Value travels a CL-deep shift pipeline; dq_o shows it in the cycle after edge T+CL+k-1, so the controller samples it at edge T+CL+k.
  - When no beat is valid, dq_o holds its last value.
- Read/write to the same address in one cycle cannot occur (single burst engine).
- LOAD MODE issued during a burst takes effect for the next READ/WRITE only.

Optional Feature:
- Macro SDRAM_MODEL_PROTO_CHECK_EN.
- When defined, err_o sets (sticky until reset) on any of:
  - ACTIVE to an already-open bank;
  - READ/WRITE to an idle bank;
  - LOAD MODE or AUTO REFRESH with any bank open;
  - a write beat with dq_oe_i=0;
  - LOAD MODE with unsupported CL or BL.
- When undefined, err_o is tied 0 and no checks are synthesized; all other behaviour is identical.

Test Plan:
- Reset, LOAD MODE addr=0x021 (CL2, BL2), ACTIVE ba=1 row=5, WRITE col=0 with dq_i=0x11223344 then 0x55667788, dqm=0, dq_oe=1; READ col=0 -> dq_o=0x11223344 sampled at edge T+2, 0x55667788 at T+3.
- LOAD MODE CL3 BL4, READ col=2 on preloaded row -> beats from columns 2,3,0,1 at edges T+3..T+6.
- WRITE 0xAABBCCDD with dqm=4'b0101 over a word holding 0x00000000 -> readback 0xAA00CC00. READ with dqm=4'b1000 on that beat -> dq_o=0x0000CC00.
- BL8 read, BURST TERMINATE at T+2 -> exactly 3 beats returned; dq_o holds afterwards. READ interrupted by WRITE at T+1 -> write lands correctly.
- cke_i low for 3 cycles mid-BL4 read -> beats delayed by exactly 3 cycles with values unchanged.
- With SDRAM_MODEL_PROTO_CHECK_EN: READ to idle bank 2 -> err_o=1 next cycle and stays 1; rst_i pulse clears it. Without the macro, the same stimulus -> err_o=0.
